// File: rtl/srt_div_arith_unit.sv
`default_nettype none
// ============================================================================
// Module   : srt_div_arith_unit
// Brief    : Registered helper datapaths for an SRT divider: leading-one
//            detector, 4-bit-group carry-lookahead adder, 3:2 compressor.
// Revision : 1.0 - initial release
// ============================================================================
module srt_div_arith_unit #(
    parameter int WIDTH     = 64,
    parameter int CSA_WIDTH = 70,
    localparam int IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 in_valid_i,
    input  logic [WIDTH-1:0]     lod_req_i,
    input  logic [WIDTH-1:0]     cla_a_i,
    input  logic [WIDTH-1:0]     cla_b_i,
    input  logic                 cla_ci_i,
    input  logic [CSA_WIDTH-1:0] csa_a_i,
    input  logic [CSA_WIDTH-1:0] csa_b_i,
    input  logic [CSA_WIDTH-1:0] csa_c_i,
    output logic                 out_valid_o,
    output logic [IDX_W-1:0]     lod_idx_o,
    output logic [WIDTH-1:0]     lod_onehot_o,
    output logic                 lod_zero_o,
    output logic [WIDTH-1:0]     cla_s_o,
    output logic                 cla_co_o,
    output logic [CSA_WIDTH-1:0] csa_s_o,
    output logic [CSA_WIDTH-1:0] csa_co_o
);

    localparam int NGRP = (WIDTH + 3) / 4;
    localparam int PW   = NGRP * 4;

    // ------------------------------------------------------------------
    // Leading-one detector: ascending scan, so the highest set bit wins
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] w_lod_idx;
    logic             w_lod_found;
    logic [WIDTH-1:0] w_lod_onehot;

    always_comb begin
        w_lod_idx   = '0;
        w_lod_found = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (lod_req_i[i]) begin
                w_lod_idx   = IDX_W'(i);
                w_lod_found = 1'b1;
            end
        end
        w_lod_onehot = w_lod_found ? (WIDTH'(1) << w_lod_idx) : '0;
    end

    // ------------------------------------------------------------------
    // Carry-lookahead adder
    // ------------------------------------------------------------------
    logic [PW-1:0]   w_a_pad;
    logic [PW-1:0]   w_b_pad;
    logic [PW-1:0]   w_g;
    logic [PW-1:0]   w_p;
    logic [PW-1:0]   w_sum_pad;
    logic [NGRP-1:0] w_gg;
    logic [NGRP-1:0] w_gp;
    logic [NGRP:0]   w_gc;
    logic            w_cla_co;

    assign w_a_pad = PW'(cla_a_i);
    assign w_b_pad = PW'(cla_b_i);
    assign w_g     = w_a_pad & w_b_pad;
    assign w_p     = w_a_pad ^ w_b_pad;

    generate
        for (genvar gi = 0; gi < NGRP; gi++) begin : g_grp
            logic [3:0] w_gl;
            logic [3:0] w_pl;
            logic [3:0] w_cl;
            logic       w_cin;

            assign w_gl  = w_g[4*gi +: 4];
            assign w_pl  = w_p[4*gi +: 4];
            assign w_cin = w_gc[gi];

            assign w_gg[gi] = w_gl[3]
                            | (w_pl[3] & w_gl[2])
                            | (w_pl[3] & w_pl[2] & w_gl[1])
                            | (w_pl[3] & w_pl[2] & w_pl[1] & w_gl[0]);
            assign w_gp[gi] = &w_pl;

            // Bit carries inside the group, flattened from the group carry-in
            assign w_cl[0] = w_cin;
            assign w_cl[1] = w_gl[0] | (w_pl[0] & w_cin);
            assign w_cl[2] = w_gl[1] | (w_pl[1] & w_gl[0])
                           | (w_pl[1] & w_pl[0] & w_cin);
            assign w_cl[3] = w_gl[2] | (w_pl[2] & w_gl[1])
                           | (w_pl[2] & w_pl[1] & w_gl[0])
                           | (w_pl[2] & w_pl[1] & w_pl[0] & w_cin);

            assign w_sum_pad[4*gi +: 4] = w_pl ^ w_cl;
        end
    endgenerate

    // Group carries as sum-of-products of group G/P terms, never chained
    always_comb begin
        logic acc;
        logic pp;
        w_gc    = '0;
        w_gc[0] = cla_ci_i;
        for (int k = 1; k <= NGRP; k++) begin
            acc = 1'b0;
            pp  = 1'b1;
            for (int j = k - 1; j >= 0; j--) begin
                acc = acc | (w_gg[j] & pp);
                pp  = pp & w_gp[j];
            end
            w_gc[k] = acc | (cla_ci_i & pp);
        end
    end

    generate
        if (PW == WIDTH) begin : g_co_exact
            assign w_cla_co = w_gc[NGRP];
        end else begin : g_co_pad
            assign w_cla_co = w_sum_pad[WIDTH];
        end
    endgenerate

    // ------------------------------------------------------------------
    // 3:2 compressor; carry vector is left unshifted for the caller
    // ------------------------------------------------------------------
    logic [CSA_WIDTH-1:0] w_csa_s;
    logic [CSA_WIDTH-1:0] w_csa_c;

    assign w_csa_s = csa_a_i ^ csa_b_i ^ csa_c_i;
    assign w_csa_c = (csa_a_i & csa_b_i) | (csa_a_i & csa_c_i) | (csa_b_i & csa_c_i);

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    logic                 r_valid;
    logic [IDX_W-1:0]     r_lod_idx;
    logic [WIDTH-1:0]     r_lod_onehot;
    logic                 r_lod_zero;
    logic [WIDTH-1:0]     r_cla_s;
    logic                 r_cla_co;
    logic [CSA_WIDTH-1:0] r_csa_s;
    logic [CSA_WIDTH-1:0] r_csa_c;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_valid      <= 1'b0;
            r_lod_idx    <= '0;
            r_lod_onehot <= '0;
            r_lod_zero   <= 1'b0;
            r_cla_s      <= '0;
            r_cla_co     <= 1'b0;
            r_csa_s      <= '0;
            r_csa_c      <= '0;
        end else begin
            r_valid <= in_valid_i;
            if (in_valid_i) begin
                r_lod_idx    <= w_lod_idx;
                r_lod_onehot <= w_lod_onehot;
                r_lod_zero   <= ~w_lod_found;
                r_cla_s      <= w_sum_pad[WIDTH-1:0];
                r_cla_co     <= w_cla_co;
                r_csa_s      <= w_csa_s;
                r_csa_c      <= w_csa_c;
            end
        end
    end

    assign out_valid_o  = r_valid;
    assign lod_idx_o    = r_lod_idx;
    assign lod_onehot_o = r_lod_onehot;
    assign lod_zero_o   = r_lod_zero;
    assign cla_s_o      = r_cla_s;
    assign cla_co_o     = r_cla_co;
    assign csa_s_o      = r_csa_s;
    assign csa_co_o     = r_csa_c;

endmodule
`default_nettype wire

// File: tb/tb_srt_div_arith_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_srt_div_arith_unit
// Brief    : Self-checking bench: directed table, corner sequences, random.
// Revision : 1.0 - initial release
// ============================================================================
module tb_srt_div_arith_unit;

    typedef struct {
        logic [63:0] lod;
        logic [63:0] a;
        logic [63:0] b;
        logic        ci;
        logic [69:0] x;
        logic [69:0] y;
        logic [69:0] z;
    } in_t;

    typedef struct {
        logic [5:0]  idx;
        logic [63:0] oh;
        logic        zero;
        logic [63:0] s;
        logic        co;
        logic [69:0] cs;
        logic [69:0] cc;
    } out_t;

    typedef struct {
        in_t  i;
        out_t e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [63:0] lod_req;
    logic [63:0] cla_a;
    logic [63:0] cla_b;
    logic        cla_ci;
    logic [69:0] csa_a;
    logic [69:0] csa_b;
    logic [69:0] csa_c;
    logic        out_valid;
    logic [5:0]  lod_idx;
    logic [63:0] lod_onehot;
    logic        lod_zero;
    logic [63:0] cla_s;
    logic        cla_co;
    logic [69:0] csa_s;
    logic [69:0] csa_co;

    int n_vec = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    srt_div_arith_unit #(.WIDTH(64), .CSA_WIDTH(70)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .in_valid_i   (in_valid),
        .lod_req_i    (lod_req),
        .cla_a_i      (cla_a),
        .cla_b_i      (cla_b),
        .cla_ci_i     (cla_ci),
        .csa_a_i      (csa_a),
        .csa_b_i      (csa_b),
        .csa_c_i      (csa_c),
        .out_valid_o  (out_valid),
        .lod_idx_o    (lod_idx),
        .lod_onehot_o (lod_onehot),
        .lod_zero_o   (lod_zero),
        .cla_s_o      (cla_s),
        .cla_co_o     (cla_co),
        .csa_s_o      (csa_s),
        .csa_co_o     (csa_co)
    );

    // Behavioural reference: priority search, plain +, ^ and majority
    function automatic out_t model(input in_t v);
        out_t        o;
        logic [64:0] sum;
        o.idx  = '0;
        o.oh   = '0;
        o.zero = (v.lod == 64'd0);
        for (int i = 63; i >= 0; i--) begin
            if (v.lod[i] && o.oh == 64'd0) begin
                o.idx   = 6'(i);
                o.oh[i] = 1'b1;
            end
        end
        sum  = {1'b0, v.a} + {1'b0, v.b} + {64'd0, v.ci};
        o.s  = sum[63:0];
        o.co = sum[64];
        o.cs = v.x ^ v.y ^ v.z;
        o.cc = (v.x & v.y) | (v.x & v.z) | (v.y & v.z);
        return o;
    endfunction

    task automatic chk(input string nm, input logic [70:0] got, input logic [70:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h required %0h", nm, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic exp_valid, input out_t e);
        chk({tag, ".valid"},  71'(out_valid),  71'(exp_valid));
        chk({tag, ".idx"},    71'(lod_idx),    71'(e.idx));
        chk({tag, ".onehot"}, 71'(lod_onehot), 71'(e.oh));
        chk({tag, ".zero"},   71'(lod_zero),   71'(e.zero));
        chk({tag, ".cla_s"},  71'(cla_s),      71'(e.s));
        chk({tag, ".cla_co"}, 71'(cla_co),     71'(e.co));
        chk({tag, ".csa_s"},  71'(csa_s),      71'(e.cs));
        chk({tag, ".csa_co"}, 71'(csa_co),     71'(e.cc));
    endtask

    task automatic drive(input in_t v, input logic vld);
        lod_req  = v.lod;
        cla_a    = v.a;
        cla_b    = v.b;
        cla_ci   = v.ci;
        csa_a    = v.x;
        csa_b    = v.y;
        csa_c    = v.z;
        in_valid = vld;
    endtask

    function automatic in_t rand_in();
        in_t v;
        int  sh;
        sh    = $urandom_range(0, 64);
        v.lod = ({$urandom, $urandom} >> sh);
        v.a   = ($urandom_range(0, 15) == 0) ? '1 : {$urandom, $urandom};
        v.b   = ($urandom_range(0, 15) == 0) ? '1 : {$urandom, $urandom};
        v.ci  = 1'($urandom);
        v.x   = 70'({$urandom, $urandom, $urandom});
        v.y   = 70'({$urandom, $urandom, $urandom});
        v.z   = 70'({$urandom, $urandom, $urandom});
        return v;
    endfunction

    out_t zero_out;
    vec_t tbl[4];

    initial begin
        in_t  vi;
        in_t  vprev;
        out_t eprev;
        out_t em;
        logic [70:0] lhs;
        logic [70:0] rhs;

        zero_out = '{idx: '0, oh: '0, zero: 1'b0, s: '0, co: 1'b0, cs: '0, cc: '0};

        tbl[0] = '{i: '{lod: 64'h0000_0100_0000_0001, a: 64'hFFFF_FFFF_FFFF_FFFF, b: 64'd1, ci: 1'b0,
                        x: 70'd5, y: 70'd3, z: 70'd6},
                   e: '{idx: 6'd40, oh: 64'h0000_0100_0000_0000, zero: 1'b0, s: 64'd0, co: 1'b1,
                        cs: 70'd0, cc: 70'd7}};
        tbl[1] = '{i: '{lod: 64'h8000_0000_0000_0000, a: 64'd5, b: 64'd7, ci: 1'b1,
                        x: 70'd0, y: 70'd0, z: 70'd0},
                   e: '{idx: 6'd63, oh: 64'h8000_0000_0000_0000, zero: 1'b0, s: 64'd13, co: 1'b0,
                        cs: 70'd0, cc: 70'd0}};
        tbl[2] = '{i: '{lod: 64'd0, a: '1, b: '1, ci: 1'b1, x: '1, y: '1, z: '1},
                   e: '{idx: 6'd0, oh: 64'd0, zero: 1'b1, s: '1, co: 1'b1, cs: '1, cc: '1}};
        tbl[3] = '{i: '{lod: 64'd1, a: 64'h8000_0000_0000_0000, b: 64'h8000_0000_0000_0000, ci: 1'b0,
                        x: 70'd1, y: 70'd0, z: 70'd0},
                   e: '{idx: 6'd0, oh: 64'd1, zero: 1'b0, s: 64'd0, co: 1'b1, cs: 70'd1, cc: 70'd0}};

        // Reset with a valid input present: input must be discarded
        rst_n = 1'b0;
        drive(tbl[0].i, 1'b1);
        repeat (2) @(posedge clk);
        #1 check_outs("reset", 1'b0, zero_out);

        // Directed table, back to back
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(tbl[k].i, 1'b1);
            @(posedge clk);
            #1 check_outs($sformatf("tbl%0d", k), 1'b1, tbl[k].e);
            @(negedge clk);
        end

        // Hold: invalid cycle keeps last results, drops valid
        drive(tbl[0].i, 1'b0);
        @(posedge clk);
        #1 check_outs("hold", 1'b0, tbl[3].e);
        @(negedge clk);

        // Mid-stream reset: in-flight input is lost, first capture after is 1 cycle
        drive(tbl[1].i, 1'b1);
        @(posedge clk);
        #1 check_outs("pre_rst", 1'b1, tbl[1].e);
        @(negedge clk);
        rst_n = 1'b0;
        drive(tbl[0].i, 1'b1);
        @(posedge clk);
        #1 check_outs("mid_rst", 1'b0, zero_out);
        @(negedge clk);
        rst_n = 1'b1;
        drive(tbl[0].i, 1'b0);
        @(posedge clk);
        #1 check_outs("rst_lost", 1'b0, zero_out);
        @(negedge clk);
        drive(tbl[2].i, 1'b1);
        @(posedge clk);
        #1 check_outs("post_rst", 1'b1, tbl[2].e);
        @(negedge clk);

        // Random stream with occasional idle cycles
        vprev = tbl[2].i;
        eprev = tbl[2].e;
        for (int k = 0; k < 10000; k++) begin
            logic vld;
            vi  = rand_in();
            vld = ($urandom_range(0, 9) != 0);
            drive(vi, vld);
            @(posedge clk);
            if (vld) begin
                em = model(vi);
                #1 check_outs("rnd", 1'b1, em);
                lhs = 71'(csa_s) + 71'({csa_co, 1'b0});
                rhs = 71'(vi.x) + 71'(vi.y) + 71'(vi.z);
                chk("rnd.csa_inv", lhs, rhs);
                vprev = vi;
                eprev = em;
            end else begin
                #1 check_outs("rnd_idle", 1'b0, eprev);
            end
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/srt_div_arith_unit.md
SRT_DIV_ARITH_UNIT -- requirements
Module: srt_div_arith_unit

Interface
REQ-001 Parameter WIDTH, default 64, SHALL set the leading-one detector and adder operand width.
REQ-002 Parameter CSA_WIDTH, default 70, SHALL set the 3:2 compressor operand width (WIDTH+6).
REQ-003 clk_i  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n_i  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 in_valid_i  input  1  SHALL qualify all operand inputs for capture this cycle.
REQ-006 lod_req_i  input  WIDTH  SHALL be the leading-one detector request vector.
REQ-007 cla_a_i, cla_b_i  input  WIDTH each  SHALL be the adder operands.
REQ-008 cla_ci_i  input  1  SHALL be the adder carry-in.
REQ-009 csa_a_i, csa_b_i, csa_c_i  input  CSA_WIDTH each  SHALL be the compressor operands.
REQ-010 out_valid_o  output  1  SHALL flag that all result outputs hold results of a captured input.
REQ-011 lod_idx_o  output  log2(WIDTH) (6 at default)  SHALL be the binary bit index of the most significant set bit of lod_req_i.
REQ-012 lod_onehot_o  output  WIDTH  SHALL be one-hot, with only the most significant set bit of lod_req_i set.
REQ-013 lod_zero_o  output  1  SHALL be 1 when lod_req_i was all zeros.
REQ-014 cla_s_o  output  WIDTH  SHALL be the adder sum; cla_co_o  output  1  SHALL be the adder carry-out.
REQ-015 csa_s_o  output  CSA_WIDTH  SHALL be the compressor sum; csa_co_o  output  CSA_WIDTH  SHALL be the compressor carry vector, unshifted.

Function
REQ-016 The block SHALL contain three independent datapaths: a priority leading-one detector, a carry-lookahead adder, and a bitwise 3:2 carry-save compressor.
REQ-017 Latency SHALL be exactly 1 cycle: inputs sampled with in_valid_i=1 at edge N SHALL appear on the outputs after edge N, with out_valid_o=1.
REQ-018 When in_valid_i=0 at an edge, out_valid_o SHALL go 0 and all result outputs SHALL hold their previous values.
REQ-019 There is no backpressure; a new capture SHALL be accepted every cycle.
REQ-020 Detector: lod_idx_o SHALL be the largest i with lod_req_i[i]=1, and lower set bits SHALL be ignored.
REQ-021 Detector boundary: when lod_req_i=0, lod_idx_o SHALL be 0, lod_onehot_o SHALL be 0 and lod_zero_o SHALL be 1; otherwise lod_zero_o SHALL be 0.
REQ-022 Adder: {cla_co_o, cla_s_o} SHALL equal cla_a_i + cla_b_i + cla_ci_i, computed exactly in WIDTH+1 bits.
REQ-023 Adder structure SHALL be carry-lookahead: 4-bit groups with generate/propagate and group-level lookahead; a ripple chain across all WIDTH bits SHALL NOT be used.
REQ-024 Compressor, per bit: csa_s_o[i] SHALL equal a^b^c, and csa_co_o[i] SHALL equal the majority (a&b)|(a&c)|(b&c).
REQ-025 Compressor invariant: csa_s_o + 2*csa_co_o SHALL equal csa_a_i+csa_b_i+csa_c_i modulo 2^(CSA_WIDTH+1); the caller applies the left shift of the carry vector.
REQ-026 All arithmetic SHALL be unsigned, and no overflow or saturation signalling SHALL be provided.

Reset
REQ-027 When rst_n_i=0 at a rising edge, out_valid_o, lod_idx_o, lod_onehot_o, lod_zero_o, cla_s_o, cla_co_o, csa_s_o and csa_co_o SHALL all become 0.
REQ-028 Reset SHALL take priority over in_valid_i, and an input presented in the reset cycle SHALL be discarded.
REQ-029 After reset release, the first capture SHALL produce outputs one cycle later, with no extra warm-up cycles.

Verification
REQ-030 Detector: lod_req_i=64'h0000_0100_0000_0001 -> lod_idx_o=40, lod_onehot_o=64'h0000_0100_0000_0000, lod_zero_o=0; lod_req_i=64'h8000_0000_0000_0000 -> idx 63.
REQ-031 Detector zero: lod_req_i=0 -> lod_idx_o=0, lod_onehot_o=0, lod_zero_o=1.
REQ-032 Adder: a=64'hFFFF_FFFF_FFFF_FFFF, b=1, ci=0 -> s=0, co=1; a=5, b=7, ci=1 -> s=13, co=0.
REQ-033 Compressor: a=5, b=3, c=6 -> csa_s_o=0, csa_co_o=7 (0+2*7=14).
REQ-034 Timing and reset: back-to-back valid inputs -> results stream one per cycle with 1-cycle latency; assert rst_n_i=0 mid-stream -> all outputs 0 at the next edge, and the in-flight input is lost.
REQ-035 Random regression: at least 10k random vectors per datapath, checked against behavioural +, ^ and majority models, and against a priority search for the detector.
